// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit saturating direction counters.
//               IF-stage lookup, trained and redirected by ID-stage resolution.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_next_pc,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_stall,
    input  logic [31:0]      id_pc,
    input  logic             id_pred_taken,
    input  logic [31:0]      id_pred_target,
    input  logic             id_branch_taken,
    input  logic [31:0]      id_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX_W-1:0] w_lk_idx;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_resolve;
    logic             w_mispredict;
    logic [31:0]      w_actual_pc;

    // IF-side lookup: pure read of registered state, so a same-cycle update
    // to the same index is only seen on the following cycle.
    assign w_lk_idx     = if_pc[IDX_W+1:2];
    assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == if_pc[31:IDX_W+2]);
    assign pred_taken   = !rst && w_lk_hit && r_ctr[w_lk_idx][1];
    assign pred_next_pc = pred_taken ? r_target[w_lk_idx] : if_pc + 32'd4;

    assign w_up_idx     = id_pc[IDX_W+1:2];
    assign w_up_tag     = id_pc[31:IDX_W+2];
    assign w_up_hit     = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_resolve    = id_valid && id_is_branch && !id_stall && !rst;
    assign w_actual_pc  = id_branch_taken ? id_target : id_pc + 32'd4;
    assign w_mispredict = w_resolve &&
                          ((id_pred_taken != id_branch_taken) ||
                           (id_branch_taken && (id_pred_target != id_target)));

    assign redirect    = w_mispredict;
    assign redirect_pc = w_mispredict ? w_actual_pc : 32'd0;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_RESET;
            end
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_resolve) begin
            if (w_up_hit) begin
                if (id_branch_taken) begin
                    if (r_ctr[w_up_idx] != 2'b11)
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                    r_target[w_up_idx] <= id_target;
                end else if (r_ctr[w_up_idx] != 2'b00) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
                end
            end else if (id_branch_taken) begin
                // Allocate weakly-taken, evicting whatever aliased here.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= id_target;
                r_ctr[w_up_idx]    <= CTR_ALLOC;
            end
            if (r_branch_cnt != {CNT_W{1'b1}})
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispredict && (r_mispred_cnt != {CNT_W{1'b1}}))
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    typedef struct {
        int          step;
        logic        pt;
        logic [31:0] pnpc;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        id_valid;
    logic        id_is_branch;
    logic        id_stall;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        id_branch_taken;
    logic [31:0] id_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   step_no;

    branch_predictor #(.ENTRIES(64), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_next_pc   (pred_next_pc),
        .id_valid       (id_valid),
        .id_is_branch   (id_is_branch),
        .id_stall       (id_stall),
        .id_pc          (id_pc),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target),
        .id_branch_taken(id_branch_taken),
        .id_target      (id_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL step %0d %s: got %h expected %h", step, name, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pred_taken",   e.step, {31'd0, pred_taken}, {31'd0, e.pt});
            check("pred_next_pc", e.step, pred_next_pc, e.pnpc);
            check("redirect",     e.step, {31'd0, redirect},   {31'd0, e.rd});
            check("redirect_pc",  e.step, redirect_pc,  e.rpc);
            check("branch_cnt",   e.step, branch_cnt,   e.bc);
            check("mispred_cnt",  e.step, mispred_cnt,  e.mc);
        end
    end

    // One cycle of stimulus plus its expected response.
    task automatic cyc(input logic r, input logic [31:0] ipc,
                       input logic v, input logic br, input logic st,
                       input logic [31:0] ipc_id, input logic ipt, input logic [31:0] ipta,
                       input logic bt, input logic [31:0] tgt,
                       input logic e_pt, input logic [31:0] e_pnpc,
                       input logic e_rd, input logic [31:0] e_rpc,
                       input logic [31:0] e_bc, input logic [31:0] e_mc);
        exp_t e;
        rst = r; if_pc = ipc;
        id_valid = v; id_is_branch = br; id_stall = st; id_pc = ipc_id;
        id_pred_taken = ipt; id_pred_target = ipta;
        id_branch_taken = bt; id_target = tgt;
        step_no++;
        e.step = step_no; e.pt = e_pt; e.pnpc = e_pnpc; e.rd = e_rd;
        e.rpc = e_rpc; e.bc = e_bc; e.mc = e_mc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] ipc, input logic e_pt, input logic [31:0] e_pnpc,
                        input logic [31:0] e_bc, input logic [31:0] e_mc);
        cyc(1'b0, ipc, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
            e_pt, e_pnpc, 1'b0, 32'd0, e_bc, e_mc);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; step_no = 0;
        rst = 1'b1; if_pc = 32'h100;
        id_valid = 1'b0; id_is_branch = 1'b0; id_stall = 1'b0; id_pc = 32'd0;
        id_pred_taken = 1'b0; id_pred_target = 32'd0; id_branch_taken = 1'b0; id_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        look(32'h100, 1'b0, 32'h104, 0, 0);
        // Train 0x100 -> 0x80 while looking it up: lookup sees old contents.
        cyc(1'b0, 32'h100, 1, 1, 0, 32'h100, 0, 32'h104, 1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80, 0, 0);
        look(32'h100, 1'b1, 32'h80, 1, 1);
        cyc(1'b0, 32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1, 1);
        cyc(1'b0, 32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 2, 1);
        // Hysteresis: two not-taken needed to flip from strongly taken.
        cyc(1'b0, 32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104, 3, 1);
        look(32'h100, 1'b1, 32'h80, 4, 2);
        cyc(1'b0, 32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104, 4, 2);
        look(32'h100, 1'b0, 32'h104, 5, 3);
        // Stalled mispredicting branch: nothing happens until stall drops.
        cyc(1'b0, 32'h100, 1, 1, 1, 32'h100, 0, 32'h104, 1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h0, 5, 3);
        cyc(1'b0, 32'h100, 1, 1, 1, 32'h100, 0, 32'h104, 1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h0, 5, 3);
        cyc(1'b0, 32'h100, 1, 1, 0, 32'h100, 0, 32'h104, 1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80, 5, 3);
        look(32'h100, 1'b1, 32'h80, 6, 4);
        // Right direction, wrong target still mispredicts.
        cyc(1'b0, 32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90, 6, 4);
        look(32'h100, 1'b1, 32'h90, 7, 5);
        // Alias 0x200 evicts 0x100.
        cyc(1'b0, 32'h100, 1, 1, 0, 32'h200, 0, 32'h204, 1, 32'h40, 1'b1, 32'h90, 1'b1, 32'h40, 7, 5);
        look(32'h100, 1'b0, 32'h104, 8, 6);
        look(32'h200, 1'b1, 32'h40, 8, 6);
        // Not-taken miss on aliasing 0x300 must not write.
        cyc(1'b0, 32'h200, 1, 1, 0, 32'h300, 0, 32'h304, 0, 32'h500, 1'b1, 32'h40, 1'b0, 32'h0, 8, 6);
        look(32'h200, 1'b1, 32'h40, 9, 6);
        cyc(1'b0, 32'h104, 1, 1, 0, 32'h104, 1, 32'h10, 1, 32'h10, 1'b0, 32'h108, 1'b0, 32'h0, 9, 6);
        look(32'h104, 1'b1, 32'h10, 10, 6);
        // Mid-stream reset with a would-be mispredict presented.
        cyc(1'b1, 32'h200, 1, 1, 0, 32'h104, 1, 32'h10, 0, 32'h10, 1'b0, 32'h204, 1'b0, 32'h0, 10, 6);
        look(32'h104, 1'b0, 32'h108, 0, 0);
        look(32'h200, 1'b0, 32'h204, 0, 0);
        // Non-branch instructions never resolve.
        cyc(1'b0, 32'h200, 1, 0, 0, 32'h200, 0, 32'h204, 1, 32'h40, 1'b0, 32'h204, 1'b0, 32'h0, 0, 0);
        cyc(1'b0, 32'h200, 0, 1, 0, 32'h200, 0, 32'h204, 1, 32'h40, 1'b0, 32'h204, 1'b0, 32'h0, 0, 0);
        look(32'h200, 1'b0, 32'h204, 0, 0);

        @(negedge clk);
        #1;
        check("queue_drained", step_no, exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
